addroundkey_stage: RTL
======================

// Module: addroundkey_stage
// PURPOSE
//  Registered AddRoundKey stage of the AES round datapath. It sits directly downstream of mixcolumns_block.
//  It XORs the mixed state with the round key; on the final round it XORs the ShiftRows state instead, bypassing MixColumns.
//  It adds valid/ready flow control with a 2-entry skid buffer so the round pipeline can stall without losing data.
//  State layout matches mixcolumns_block: columns are consecutive, column 0 is on the MSB.
// PARAMETERS
//  NB_BYTE   8   bits per byte; any value other than 8 sets the BAD_CONF localparam
//  N_BYTES   16  bytes per state; any value other than 16 sets BAD_CONF
//  N_ROUNDS  14  highest legal round index (AES-256)
//  NB_ROUND  4   width of the round-index tag
// PORTS
//  i_clock          in   1                 single clock; all state updates on its rising edge
//  i_reset_n        in   1                 asynchronous, active-low reset
//  i_mixcol_state   in   N_BYTES*NB_BYTE   o_state of mixcolumns_block
//  i_shrows_state   in   N_BYTES*NB_BYTE   ShiftRows state, used only when i_last_round=1
//  i_round_key      in   N_BYTES*NB_BYTE   round key for this round
//  i_round          in   NB_ROUND          round index tag, carried through
//  i_last_round     in   1                 selects the MixColumns bypass
//  i_valid          in   1                 upstream beat valid
//  o_ready          out  1                 stage can accept a beat
//  o_state          out  N_BYTES*NB_BYTE   AddRoundKey result
//  o_round          out  NB_ROUND          round tag of o_state
//  o_last           out  1                 o_state is the cipher output
//  o_valid          out  1                 o_state / o_round / o_last valid
//  i_ready          in   1                 downstream accepts
//  o_round_err      out  1                 sticky: a beat was accepted with i_round > N_ROUNDS
// BEHAVIOUR
//  - Reset (async assert, release synchronous to i_clock):
//      o_state=0, o_round=0, o_last=0, o_valid=0, o_round_err=0, o_ready=1, FSM=EMPTY.
//  - Accept on i_valid & o_ready. Output beat leaves on o_valid & i_ready.
//  - Datapath: result = (i_last_round ? i_shrows_state : i_mixcol_state) ^ i_round_key, a pure bytewise XOR.
//    The result and its tags {i_round, i_last_round} are captured together.
//  - Latency: 1 clock from accept to o_valid when the FSM is EMPTY. No combinational path from input data to output.
//  - FSM states: EMPTY (output register invalid), FULL (output register valid, skid empty), SKID (both valid).
//      EMPTY: accept -> FULL (output register loaded).
//      FULL:  accept & !i_ready -> SKID (skid loaded).
//             accept & i_ready -> FULL (output register reloaded).
//             !accept & i_ready -> EMPTY.
//             otherwise hold.
//      SKID:  i_ready -> FULL (skid moves to the output register); no accept is possible.
//  - o_ready is a registered output: o_ready = (next FSM != SKID). It never depends combinationally on i_ready.
//  - Ordering is strictly FIFO and beats are never dropped or duplicated.
//    While o_valid=1 and i_ready=0, o_state/o_round/o_last hold stable.
//  - o_round_err: set on an accepted beat with i_round > N_ROUNDS and held until reset. The beat is still passed through.
//  - Inputs are ignored when i_valid=0 or o_ready=0; their X values must not reach any register.
//  - Reset mid-operation: all buffered beats are discarded and the stage returns to EMPTY with o_ready=1.
//  - Throughput: 1 beat/clock sustained while i_ready=1.
// TESTING
//  1 FIPS-197 App.B round 1: mix=046681e5e0cb199a48f8d37a2806264c, key=a0fafe1788542cb123a339392a6c7605, last=0
//    -> o_state=a49c7ff2689f352b6b5bea43026a5049 one clock later.
//  2 Final round: shrows=e9317db5cb322c723d2e895faf090794, key=d014f9a8c9ee2589e13f0cc8b6630ca6, last=1, mix=random
//    -> o_state=3925841d02dc09fbdc118597196a0b32, o_last=1.
//  3 Backpressure: send beats r=1,2,3 back-to-back with i_ready=0
//    -> FSM reaches SKID, o_ready drops after the 2nd beat, beat 3 is held upstream.
//    Then release i_ready -> outputs 1,2,3 in order, no loss, o_state stable while stalled.
//  4 Streaming: 100 random beats with i_valid=i_ready=1 -> 100 outputs, one per clock, each equal to the reference XOR model.
//  5 Random i_valid/i_ready at 50% for 10k beats -> scoreboard match, no duplicates, handshake assertions hold.
//  6 i_round=15 accepted -> o_round_err=1 and stays 1; assert i_reset_n=0 while in SKID
//    -> o_valid=0, o_ready=1, o_round_err=0 immediately (async).

Source files
------------

// File: rtl/addroundkey_stage_if.sv
// Handshake and data bundle for the AddRoundKey stage.
// Signal names keep the stage's i_/o_ view: the slave modport is the stage,
// the master modport is whoever drives it (upstream round logic and downstream sink).
interface addroundkey_stage_if #(
    parameter int NB_STATE = 128,
    parameter int NB_ROUND = 4
);
    logic [NB_STATE-1:0] i_mixcol_state;
    logic [NB_STATE-1:0] i_shrows_state;
    logic [NB_STATE-1:0] i_round_key;
    logic [NB_ROUND-1:0] i_round;
    logic                i_last_round;
    logic                i_valid;
    logic                o_ready;
    logic [NB_STATE-1:0] o_state;
    logic [NB_ROUND-1:0] o_round;
    logic                o_last;
    logic                o_valid;
    logic                i_ready;
    logic                o_round_err;

    modport slave (
        input  i_mixcol_state, i_shrows_state, i_round_key, i_round, i_last_round,
        input  i_valid, i_ready,
        output o_ready, o_state, o_round, o_last, o_valid, o_round_err
    );

    modport master (
        output i_mixcol_state, i_shrows_state, i_round_key, i_round, i_last_round,
        output i_valid, i_ready,
        input  o_ready, o_state, o_round, o_last, o_valid, o_round_err
    );
endinterface

// File: rtl/addroundkey_stage.sv
// Registered AddRoundKey stage of the AES round datapath.
// Result = (last ? ShiftRows state : MixColumns state) ^ round key, captured with
// its round tags into an output register backed by a one-entry skid register so
// the pipeline can stall for a cycle without losing a beat. o_ready is registered
// and never depends combinationally on i_ready.
module addroundkey_stage #(
    parameter int NB_BYTE  = 8,
    parameter int N_BYTES  = 16,
    parameter int N_ROUNDS = 14,
    parameter int NB_ROUND = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    addroundkey_stage_if.slave   bus
);
    localparam int NB_STATE = N_BYTES * NB_BYTE;
    localparam bit BAD_CONF = (NB_BYTE != 8) || (N_BYTES != 16);
    localparam logic [NB_ROUND-1:0] MAX_ROUND = NB_ROUND'(N_ROUNDS);

    // Only the AES geometry is meaningful; other sizes still elaborate as a plain XOR stage.
    if (BAD_CONF) begin : g_bad_conf
    end

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    function automatic logic [NB_STATE-1:0] f_add_round_key(
        input logic                last,
        input logic [NB_STATE-1:0] mix,
        input logic [NB_STATE-1:0] shr,
        input logic [NB_STATE-1:0] key
    );
        logic [NB_STATE-1:0] sel;
        sel = last ? shr : mix;
        return sel ^ key;
    endfunction

    state_t              r_state;
    state_t              w_next_state;
    logic                w_accept;
    logic                w_load_out;
    logic                w_load_skid;
    logic                w_out_from_skid;
    logic [NB_STATE-1:0] w_result;

    logic [NB_STATE-1:0] r_out_state;
    logic [NB_ROUND-1:0] r_out_round;
    logic                r_out_last;
    logic [NB_STATE-1:0] r_skid_state;
    logic [NB_ROUND-1:0] r_skid_round;
    logic                r_skid_last;
    logic                r_valid;
    logic                r_ready;
    logic                r_round_err;

    assign w_accept = bus.i_valid & r_ready;
    assign w_result = f_add_round_key(bus.i_last_round, bus.i_mixcol_state,
                                      bus.i_shrows_state, bus.i_round_key);

    // Next-state and register-load decode for the EMPTY/FULL/SKID buffer.
    always_comb begin
        w_next_state    = r_state;
        w_load_out      = 1'b0;
        w_load_skid     = 1'b0;
        w_out_from_skid = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_next_state = ST_FULL;
                    w_load_out   = 1'b1;
                end else begin
                    w_next_state = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_accept && !bus.i_ready) begin
                    w_next_state = ST_SKID;
                    w_load_skid  = 1'b1;
                end else if (w_accept && bus.i_ready) begin
                    w_next_state = ST_FULL;
                    w_load_out   = 1'b1;
                end else if (bus.i_ready) begin
                    w_next_state = ST_EMPTY;
                end else begin
                    w_next_state = ST_FULL;
                end
            end
            ST_SKID: begin
                if (bus.i_ready) begin
                    w_next_state    = ST_FULL;
                    w_out_from_skid = 1'b1;
                end else begin
                    w_next_state = ST_SKID;
                end
            end
            default: begin
                w_next_state = ST_EMPTY;
            end
        endcase
    end

    // FSM state plus registered o_valid / o_ready derived from the next state.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_EMPTY;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_valid <= (w_next_state != ST_EMPTY);
            r_ready <= (w_next_state != ST_SKID);
        end
    end

    // Output register: refilled from the skid entry first, otherwise from the datapath.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_out_state <= '0;
            r_out_round <= '0;
            r_out_last  <= 1'b0;
        end else if (w_out_from_skid) begin
            r_out_state <= r_skid_state;
            r_out_round <= r_skid_round;
            r_out_last  <= r_skid_last;
        end else if (w_load_out) begin
            r_out_state <= w_result;
            r_out_round <= bus.i_round;
            r_out_last  <= bus.i_last_round;
        end
    end

    // Skid register: catches the beat accepted while the output register is stalled.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_skid_state <= '0;
            r_skid_round <= '0;
            r_skid_last  <= 1'b0;
        end else if (w_load_skid) begin
            r_skid_state <= w_result;
            r_skid_round <= bus.i_round;
            r_skid_last  <= bus.i_last_round;
        end
    end

    // Sticky flag for any accepted beat whose round tag exceeds the last legal round.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_round_err <= 1'b0;
        end else if (w_accept && (bus.i_round > MAX_ROUND)) begin
            r_round_err <= 1'b1;
        end
    end

    assign bus.o_state     = r_out_state;
    assign bus.o_round     = r_out_round;
    assign bus.o_last      = r_out_last;
    assign bus.o_valid     = r_valid;
    assign bus.o_ready     = r_ready;
    assign bus.o_round_err = r_round_err;
endmodule
